// File: rtl/led_frame_sched.sv
// Frame scheduler: arbitrates two frame requesters and shifts each frame MSB-first to an LED chain.
// Define LED_SCHED_FIXED_PRIO_EN for fixed priority (req0 wins ties); otherwise round-robin.
module led_frame_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             led_clk,
  output logic             led_do,
  output logic             led_clr,
  output logic             led_pen
);

  localparam int unsigned PhW  = $clog2(2 * DIV + 1);
  localparam int unsigned BitW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StClear, StShift, StLatch} state_e;

  state_e            state_q, state_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              pen_q, pen_d;
  logic              grant1;

`ifdef LED_SCHED_FIXED_PRIO_EN
  assign grant1 = req1 & ~req0;
`else
  logic last_grant_q, last_grant_d;

  // On a tie, grant the requester that was not served last.
  assign grant1 = req1 & (~req0 | ~last_grant_q);
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    pen_d   = pen_q;
`ifndef LED_SCHED_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StClear;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          sr_d    = grant1 ? data1 : data0;
          phase_d = '0;
          bit_d   = '0;
          pen_d   = 1'b0;
`ifndef LED_SCHED_FIXED_PRIO_EN
          last_grant_d = grant1;
`endif
        end
      end
      StClear: begin
        if (phase_q == PhW'(DIV - 1)) begin
          state_d = StShift;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StShift: begin
        if (phase_q == PhW'(2 * DIV - 1)) begin
          phase_d = '0;
          // Bit counter holds at the last bit so it never wraps.
          if (bit_q == BitW'(WIDTH - 1)) begin
            state_d = StLatch;
          end else begin
            bit_d = bit_q + 1'b1;
            sr_d  = sr_q << 1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StLatch: begin
        pen_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      pen_q   <= 1'b0;
`ifndef LED_SCHED_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      pen_q   <= pen_d;
`ifndef LED_SCHED_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = (state_q != StIdle);
  assign led_clk = (state_q == StShift) && (phase_q >= PhW'(DIV));
  assign led_do  = (state_q == StShift) && sr_q[WIDTH-1];
  assign led_clr = (state_q != StClear);
  assign led_pen = pen_q || (state_q == StLatch);

endmodule
